id_ex_stage: RTL and testbench

// - ID->EX pipeline stage of the 5-stage MIPS pipeline. Sits directly downstream of the register file.
// - Drives the register-file read addresses from the IF/ID instruction.
// - Captures data1/data2, the decoded control word and the extended immediate into the ID/EX register.
// - Detects load-use hazards, inserts bubbles and honours branch flushes. Counts stall cycles.

---
 rtl/id_ex_stage_pkg.sv | 59 +++++
 rtl/id_ex_stage_hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word layout, opcodes,
// instruction field slicing and the immediate extender.
package id_ex_stage_pkg;

  // Control word {regWrite,memToReg,memRead,memWrite,branch,aluSrc,regDst,aluOp[1:0]}
  localparam int CTRL_WIDTH    = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;

  function automatic logic [5:0] f_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [15:0] f_imm16(input logic [31:0] instr);
    return instr[15:0];
  endfunction

  // Logical immediates are zero-extended; everything else (LUI included,
  // which EX reshapes itself) is sign-extended.
  function automatic logic [31:0] ext_imm(input logic [31:0] instr);
    logic [5:0]  op;
    logic [15:0] imm;
    op  = f_opcode(instr);
    imm = f_imm16(instr);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
      return {16'h0000, imm};
    end
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: stalls ID when the load sitting in EX writes a
// register the ID instruction reads. A pending flush overrides the stall.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       flush_i,
  output logic       hazard_stall_o
);

  logic reg_match;

  // $0 is never a real dependency.
  always_comb begin
    reg_match      = (ex_rt_i != 5'd0) && ((ex_rt_i == rs_i) || (ex_rt_i == rt_i));
    hazard_stall_o = id_valid_i && ex_valid_i && ex_mem_read_i && !flush_i && reg_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: register-file address drive, ID/EX pipeline
// register with bubble/flush insertion, immediate extension and a
// saturating stall-cycle counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              flush,
  output logic [4:0]        rf_read1,
  output logic [4:0]        rf_read2,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_data1,
  output logic [31:0]       ex_data2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [4:0]        id_rs;
  logic [4:0]        id_rt;

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [31:0]       ex_pc4_q;
  logic [31:0]       ex_data1_q;
  logic [31:0]       ex_data2_q;
  logic [31:0]       ex_imm_q;
  logic [4:0]        ex_rs_q;
  logic [4:0]        ex_rt_q;
  logic [4:0]        ex_rd_q;
  logic [4:0]        ex_shamt_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign id_rs    = f_rs(id_instr);
  assign id_rt    = f_rt(id_instr);
  assign rf_read1 = id_rs;
  assign rf_read2 = id_rt;

  hazard_detect u_hazard_detect (
    .id_valid_i     (id_valid),
    .rs_i           (id_rs),
    .rt_i           (id_rt),
    .ex_valid_i     (ex_valid_q),
    .ex_mem_read_i  (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i        (ex_rt_q),
    .flush_i        (flush),
    .hazard_stall_o (hazard_stall)
  );

  // Next valid/control word: flush and bubble both turn the slot into a NOP;
  // the data fields load regardless since a dead slot ignores them.
  always_comb begin
    ex_valid_d = id_valid;
    ex_ctrl_d  = id_valid ? id_ctrl : '0;
    if (flush || hazard_stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ID/EX register and stall counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_pc4_q    <= '0;
      ex_data1_q  <= '0;
      ex_data2_q  <= '0;
      ex_imm_q    <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_shamt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_pc4_q    <= id_pc4;
      ex_data1_q  <= rf_data1;
      ex_data2_q  <= rf_data2;
      ex_imm_q    <= ext_imm(id_instr);
      ex_rs_q     <= id_rs;
      ex_rt_q     <= id_rt;
      ex_rd_q     <= f_rd(id_instr);
      ex_shamt_q  <= f_shamt(id_instr);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_pc4    = ex_pc4_q;
  assign ex_data1  = ex_data1_q;
  assign ex_data2  = ex_data2_q;
  assign ex_imm    = ex_imm_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_rd     = ex_rd_q;
  assign ex_shamt  = ex_shamt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage, built with a 4-bit stall counter so
// saturation is reachable quickly.
module tb_id_ex_stage;

  localparam int TB_CNT_W = 4;

  localparam logic [8:0] C_LW   = 9'b1_1100_1000;
  localparam logic [8:0] C_RTYP = 9'b1_0000_0110;
  localparam logic [8:0] C_ADDI = 9'b1_0000_1000;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic [31:0]         id_instr;
  logic [31:0]         id_pc4;
  logic [8:0]          id_ctrl;
  logic [31:0]         rf_data1;
  logic [31:0]         rf_data2;
  logic                flush;
  logic [4:0]          rf_read1;
  logic [4:0]          rf_read2;
  logic                hazard_stall;
  logic                ex_valid;
  logic [8:0]          ex_ctrl;
  logic [31:0]         ex_pc4;
  logic [31:0]         ex_data1;
  logic [31:0]         ex_data2;
  logic [31:0]         ex_imm;
  logic [4:0]          ex_rs;
  logic [4:0]          ex_rt;
  logic [4:0]          ex_rd;
  logic [4:0]          ex_shamt;
  logic [TB_CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(9), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2), .flush(flush),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic                valid;
    logic [8:0]          ctrl;
    logic [31:0]         pc4;
    logic [31:0]         d1;
    logic [31:0]         d2;
    logic [31:0]         imm;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [TB_CNT_W-1:0] cnt;
    logic                full;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state of the EX slot
  logic                m_valid = 1'b0;
  logic [8:0]          m_ctrl  = '0;
  logic [4:0]          m_rt    = '0;
  logic [TB_CNT_W-1:0] m_cnt   = '0;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t got(input logic full);
    exp_t g;
    g       = '0;
    g.valid = ex_valid;
    g.ctrl  = ex_ctrl;
    g.cnt   = stall_cnt;
    g.full  = full;
    if (full) begin
      g.pc4   = ex_pc4;
      g.d1    = ex_data1;
      g.d2    = ex_data2;
      g.imm   = ex_imm;
      g.rs    = ex_rs;
      g.rt    = ex_rt;
      g.rd    = ex_rd;
      g.shamt = ex_shamt;
    end
    return g;
  endfunction

  // Apply one ID-side vector mid-cycle, predict the next EX contents and queue them.
  task automatic drive(input logic r, v, input logic [31:0] ins, pc, input logic [8:0] c,
                       input logic [31:0] a, b, input logic f, output logic hz);
    exp_t       e;
    logic [5:0] op;
    @(negedge clk);
    rst = r; id_valid = v; id_instr = ins; id_pc4 = pc; id_ctrl = c;
    rf_data1 = a; rf_data2 = b; flush = f;
    #1;
    hz = v && m_valid && m_ctrl[6] && !f && (m_rt != 5'd0) &&
         ((m_rt == ins[25:21]) || (m_rt == ins[20:16]));
    e  = '0;
    op = ins[31:26];
    if (!r) begin
      e.full = 1'b1;
      m_cnt  = '0;
    end else begin
      e.valid = v && !hz && !f;
      e.ctrl  = e.valid ? c : 9'd0;
      e.full  = !f;
      if (!f) begin
        e.pc4   = pc;
        e.d1    = a;
        e.d2    = b;
        e.imm   = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, ins[15:0]}
                                                             : {{16{ins[15]}}, ins[15:0]};
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.rd    = ins[15:11];
        e.shamt = ins[10:6];
      end
      if (hz && m_cnt != {TB_CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    e.cnt   = m_cnt;
    m_valid = e.valid;
    m_ctrl  = e.ctrl;
    m_rt    = (r && !f) ? ins[20:16] : 5'd0;
    // After a flush the rt field is don't-care; track the real DUT slot via a follow-up.
    if (r && f) m_rt = ins[20:16];
    sb.push_back(e);
  endtask

  task automatic tick(output exp_t e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e, g;
    logic hz;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'($urandom), $urandom, $urandom, 9'($urandom), $urandom, $urandom,
            1'($urandom), hz);
      tick(e);
      g = got(e.full);
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %h exp %h", i, g, e);
      end
    end
    n_vec++;
    if (hazard_stall !== 1'b0 || stall_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_hazard_cnt: got hz=%b cnt=%h exp hz=0 cnt=0", hazard_stall, stall_cnt);
    end
  endtask

  task automatic test_normal_load();
    exp_t e, g;
    logic hz;
    drive(1'b1, 1'b1, mk_i(6'h08, 5'd1, 5'd2, 16'hFFFC), 32'h0000_1004, C_ADDI,
          32'd7, 32'h55, 1'b0, hz);
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_imm !== 32'hFFFF_FFFC || ex_data1 !== 32'd7 || ex_rt !== 5'd2 ||
        ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL normal_addi: got %h exp %h (imm=%h d1=%h rt=%0d v=%b)", g, e,
               ex_imm, ex_data1, ex_rt, ex_valid);
    end
    // sign extension of a non-logical opcode with bit 15 set
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd4, 5'd9, 16'h8000), 32'h0000_1008, C_LW,
          32'h100, 32'h0, 1'b0, hz);
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_imm !== 32'hFFFF_8000) begin
      n_err++;
      $display("FAIL sign_ext_lw: got %h exp %h (imm=%h)", g, e, ex_imm);
    end
  endtask

  task automatic test_zero_ext();
    exp_t        e, g;
    logic        hz;
    logic [5:0]  ops[3] = '{6'h0C, 6'h0D, 6'h0E};
    logic [15:0] imms[3] = '{16'hFFFF, 16'h8001, 16'hC0DE};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, mk_i(ops[i], 5'd1, 5'd3, imms[i]), 32'h2000 + 32'(i), C_ADDI,
            32'd1, 32'd2, 1'b0, hz);
      tick(e);
      g = got(e.full);
      n_vec++;
      if (g !== e || ex_imm !== {16'h0, imms[i]}) begin
        n_err++;
        $display("FAIL zero_ext[%0d]: got %h exp %h (imm=%h)", i, g, e, ex_imm);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e, g;
    logic hz;
    // LW $5 then ADD $6,$5,$1: one bubble then ADD enters
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd1, 5'd5, 16'h0010), 32'h3004, C_LW, 32'h40, 32'h0, 1'b0, hz);
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL lu_load: got %h exp %h", g, e); end
    drive(1'b1, 1'b1, mk_r(5'd5, 5'd1, 5'd6), 32'h3008, C_RTYP, 32'h11, 32'h22, 1'b0, hz);
    n_vec++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall_rs: got hz=%b exp 1", hazard_stall);
    end
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL lu_bubble: got %h exp %h", g, e);
    end
    drive(1'b1, 1'b1, mk_r(5'd5, 5'd1, 5'd6), 32'h3008, C_RTYP, 32'h11, 32'h22, 1'b0, hz);
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_one_cycle: got hz=%b exp 0", hazard_stall);
    end
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL lu_add_enters: got %h exp %h", g, e);
    end
    // match on rt: LW $7 then ADD $8,$1,$7
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd2, 5'd7, 16'h0), 32'h300C, C_LW, 32'h0, 32'h0, 1'b0, hz);
    tick(e);
    drive(1'b1, 1'b1, mk_r(5'd1, 5'd7, 5'd8), 32'h3010, C_RTYP, 32'h3, 32'h4, 1'b0, hz);
    n_vec++;
    if (hazard_stall !== 1'b1 || hz !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall_rt: got hz=%b exp 1", hazard_stall);
    end
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || stall_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL lu_rt_bubble: got %h exp %h", g, e);
    end
    drive(1'b1, 1'b1, mk_r(5'd1, 5'd7, 5'd8), 32'h3010, C_RTYP, 32'h3, 32'h4, 1'b0, hz);
    tick(e);
    // LW $0 then ADD $6,$0,$1: no stall
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd1, 5'd0, 16'h4), 32'h3014, C_LW, 32'h0, 32'h0, 1'b0, hz);
    tick(e);
    drive(1'b1, 1'b1, mk_r(5'd0, 5'd1, 5'd6), 32'h3018, C_RTYP, 32'h0, 32'h9, 1'b0, hz);
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_rt_zero: got hz=%b exp 0", hazard_stall);
    end
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_valid !== 1'b1 || stall_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL lu_rt_zero_load: got %h exp %h", g, e);
    end
  endtask

  task automatic test_flush();
    exp_t e, g;
    logic hz;
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd1, 5'd5, 16'h0), 32'h4004, C_LW, 32'h0, 32'h0, 1'b0, hz);
    tick(e);
    drive(1'b1, 1'b1, mk_r(5'd5, 5'd5, 5'd6), 32'h4008, C_RTYP, 32'h1, 32'h1, 1'b1, hz);
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_hides_stall: got hz=%b exp 0", hazard_stall);
    end
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL flush_kill: got %h exp %h", g, e);
    end
    // refill the slot so the model's rt tracks the DUT again
    drive(1'b1, 1'b1, mk_r(5'd1, 5'd2, 5'd3), 32'h400C, C_RTYP, 32'h5, 32'h6, 1'b0, hz);
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL flush_recover: got %h exp %h", g, e); end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e, g;
    logic hz;
    drive(1'b1, 1'b1, mk_i(6'h23, 5'd1, 5'd5, 16'h0), 32'h5004, C_LW, 32'h0, 32'h0, 1'b0, hz);
    tick(e);
    drive(1'b0, 1'b1, mk_r(5'd5, 5'd1, 5'd6), 32'h5008, C_RTYP, 32'h1, 32'h2, 1'b0, hz);
    tick(e);
    g = got(e.full);
    n_vec++;
    if (g !== e || ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid_stall: got %h exp %h", g, e);
    end
    drive(1'b1, 1'b1, mk_r(5'd5, 5'd1, 5'd6), 32'h5008, C_RTYP, 32'h1, 32'h2, 1'b0, hz);
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_stall_hz: got hz=%b exp 0", hazard_stall);
    end
    tick(e);
  endtask

  task automatic test_back_to_back();
    exp_t        e, g;
    logic        hz;
    logic [5:0]  ops[4] = '{6'h23, 6'h00, 6'h0C, 6'h08};
    logic [5:0]  op;
    logic [31:0] ins;
    logic [8:0]  c;
    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 3)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      c   = (op == 6'h23) ? C_LW : 9'($urandom);
      drive(1'b1, ($urandom_range(0, 7) != 0), ins, $urandom, c, $urandom, $urandom,
            ($urandom_range(0, 9) == 0), hz);
      n_vec++;
      if (hazard_stall !== hz) begin
        n_err++;
        $display("FAIL b2b_hz[%0d]: got %b exp %b", i, hazard_stall, hz);
      end
      tick(e);
      g = got(e.full);
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h exp %h", i, g, e);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e, g;
    logic hz;
    // LW $5,0($5) held in ID depends on itself in EX: stall every other cycle
    for (int i = 0; i < 44; i++) begin
      drive(1'b1, 1'b1, mk_i(6'h23, 5'd5, 5'd5, 16'h0), 32'h6004, C_LW, 32'h7, 32'h0, 1'b0, hz);
      n_vec++;
      if (hazard_stall !== hz) begin
        n_err++;
        $display("FAIL sat_hz[%0d]: got %b exp %b", i, hazard_stall, hz);
      end
      tick(e);
      g = got(e.full);
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL sat_seq[%0d]: got %h exp %h", i, g, e);
      end
      if (i == 39 || i == 43) begin
        n_vec++;
        if (stall_cnt !== 4'hF) begin
          n_err++;
          $display("FAIL sat_hold[%0d]: got %h exp f", i, stall_cnt);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc4 = '0; id_ctrl = '0;
    rf_data1 = '0; rf_data2 = '0; flush = 1'b0;
    test_reset();
    test_normal_load();
    test_zero_ext();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
